dcj11_bus_master: RTL and testbench

Synthesizable DCJ11-side bus cycle initiator: it emulates the CPU's ALE_n/SCTL_n/BUFCTL_n/AIO/DAL sequencing so the memory and ODT responder can be exercised on a TangNano 20K with no DCJ11 fitted. A local request/response port launches one bus transaction at a time, and read data is returned from the sampled DAL. The block sits in place of the CPU socket and is used in loopback builds and on the bench.

---
 rtl/dcj11_bus_master.sv | 197 +++++++++++++++++++
 tb/tb_dcj11_bus_master.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcj11_bus_master.sv
// dcj11_bus_master: stands in for the DCJ11 socket and sequences ALE_n/SCTL_n/BUFCTL_n/AIO/DAL
// for one local request at a time. Per-class cycle counters are added when DCJ11_MASTER_STATS_EN is defined.
module dcj11_bus_master #(
    parameter int SYSCLK_FRQ = 27_000_000,
    parameter int T_AS       = 2,
    parameter int T_AH       = 2,
    parameter int T_ACC      = 4,
    parameter int T_STRB     = 3
) (
    input  logic        sys_clk,
    input  logic        RESET_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_aio,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic [15:0] dal_out,
    output logic        dal_oe,
    input  logic [15:0] dal_in,
    output logic [3:0]  AIO,
    output logic        ALE_n,
    output logic        SCTL_n,
    output logic        BUFCTL_n,
    output logic [2:0]  dbg_state
`ifdef DCJ11_MASTER_STATS_EN
    ,
    input  logic        stat_clr,
    output logic [15:0] stat_rd,
    output logic [15:0] stat_wr,
    output logic [15:0] stat_nonio
`endif
);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_ready is only high in IDLE, and rsp_valid is a single-cycle pulse in END.

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ALE, S_DATA, S_STRB, S_END
    } state_t;

    typedef enum logic [1:0] {
        CLS_NONIO, CLS_READ, CLS_WRITE
    } cls_t;

    // SYSCLK_FRQ is informational; phase lengths are given in cycles (max 256).
    localparam int CNT_W = (SYSCLK_FRQ > 0) ? 8 : 8;
    localparam int AS    = (T_AS   < 1) ? 1 : T_AS;
    localparam int AH    = (T_AH   < 1) ? 1 : T_AH;
    localparam int ACC   = (T_ACC  < 1) ? 1 : T_ACC;
    localparam int STRB  = (T_STRB < 1) ? 1 : T_STRB;
    localparam logic [CNT_W-1:0] AS_M1   = CNT_W'(AS - 1);
    localparam logic [CNT_W-1:0] AH_M1   = CNT_W'(AH - 1);
    localparam logic [CNT_W-1:0] ACC_M1  = CNT_W'(ACC - 1);
    localparam logic [CNT_W-1:0] STRB_M1 = CNT_W'(STRB - 1);

    state_t           state;
    cls_t             cls_q;
    logic [15:0]      wdata_q;
    logic [CNT_W-1:0] cnt;

    function automatic cls_t decode_cls(input logic [3:0] aio);
        case (aio)
            4'b1000, 4'b1001, 4'b1010, 4'b1011,
            4'b1100, 4'b1101, 4'b1110:            decode_cls = CLS_READ;
            4'b0001, 4'b0011, 4'b0101:            decode_cls = CLS_WRITE;
            default:                              decode_cls = CLS_NONIO;
        endcase
    endfunction

    assign dbg_state = state;

    always_ff @(posedge sys_clk or negedge RESET_n) begin
        if (!RESET_n) begin
            state     <= S_IDLE;
            cls_q     <= CLS_NONIO;
            wdata_q   <= 16'h0000;
            cnt       <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 16'h0000;
            dal_out   <= 16'h0000;
            dal_oe    <= 1'b0;
            AIO       <= 4'b1111;
            ALE_n     <= 1'b1;
            SCTL_n    <= 1'b1;
            BUFCTL_n  <= 1'b1;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        state     <= S_ADDR;
                        cnt       <= AS_M1;
                        req_ready <= 1'b0;
                        cls_q     <= decode_cls(req_aio);
                        // A byte write presents its data on both DAL halves.
                        wdata_q   <= (req_aio == 4'b0011) ? {req_wdata[7:0], req_wdata[7:0]}
                                                          : req_wdata;
                        dal_oe    <= 1'b1;
                        dal_out   <= req_addr;
                        AIO       <= req_aio;
                    end
                end
                S_ADDR: begin
                    if (cnt == '0) begin
                        state <= S_ALE;
                        cnt   <= AH_M1;
                        ALE_n <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_ALE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (cls_q == CLS_NONIO) begin
                        state     <= S_END;
                        ALE_n     <= 1'b1;
                        SCTL_n    <= 1'b1;
                        BUFCTL_n  <= 1'b1;
                        dal_oe    <= 1'b0;
                        AIO       <= 4'b1111;
                        rsp_valid <= 1'b1;
                    end else begin
                        state <= S_DATA;
                        cnt   <= ACC_M1;
                        if (cls_q == CLS_READ) begin
                            dal_oe   <= 1'b0;
                            BUFCTL_n <= 1'b0;
                        end else begin
                            dal_oe  <= 1'b1;
                            dal_out <= wdata_q;
                        end
                    end
                end
                S_DATA: begin
                    if (cnt == '0) begin
                        state  <= S_STRB;
                        cnt    <= STRB_M1;
                        SCTL_n <= 1'b0;
                        // Read data is captured on the same edge SCTL_n falls.
                        if (cls_q == CLS_READ) begin
                            rsp_rdata <= dal_in;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_STRB: begin
                    if (cnt == '0) begin
                        state     <= S_END;
                        ALE_n     <= 1'b1;
                        SCTL_n    <= 1'b1;
                        BUFCTL_n  <= 1'b1;
                        dal_oe    <= 1'b0;
                        AIO       <= 4'b1111;
                        rsp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_END: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef DCJ11_MASTER_STATS_EN
    // Each completed cycle is counted once, in END; clear has priority.
    always_ff @(posedge sys_clk or negedge RESET_n) begin
        if (!RESET_n) begin
            stat_rd    <= 16'h0000;
            stat_wr    <= 16'h0000;
            stat_nonio <= 16'h0000;
        end else if (stat_clr) begin
            stat_rd    <= 16'h0000;
            stat_wr    <= 16'h0000;
            stat_nonio <= 16'h0000;
        end else if (state == S_END) begin
            case (cls_q)
                CLS_READ:  if (stat_rd    != 16'hFFFF) stat_rd    <= stat_rd    + 16'd1;
                CLS_WRITE: if (stat_wr    != 16'hFFFF) stat_wr    <= stat_wr    + 16'd1;
                default:   if (stat_nonio != 16'hFFFF) stat_nonio <= stat_nonio + 16'd1;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_dcj11_bus_master.sv
// Bench for dcj11_bus_master: a DAL memory/GP responder on the bus side, a request-level memory
// model for expected read data, a directed vector table, a reset-abort sequence and random traffic.
module tb_dcj11_bus_master;

    localparam int T_AS   = 2;
    localparam int T_AH   = 2;
    localparam int T_ACC  = 4;
    localparam int T_STRB = 3;

    logic        sys_clk;
    logic        RESET_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_aio;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic [15:0] dal_out;
    logic        dal_oe;
    logic [15:0] dal_in;
    logic [3:0]  AIO;
    logic        ALE_n;
    logic        SCTL_n;
    logic        BUFCTL_n;
    logic [2:0]  dbg_state;
`ifdef DCJ11_MASTER_STATS_EN
    logic        stat_clr;
    logic [15:0] stat_rd;
    logic [15:0] stat_wr;
    logic [15:0] stat_nonio;
`endif

    dcj11_bus_master #(
        .SYSCLK_FRQ(27_000_000), .T_AS(T_AS), .T_AH(T_AH), .T_ACC(T_ACC), .T_STRB(T_STRB)
    ) dut (
        .sys_clk(sys_clk), .RESET_n(RESET_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_aio(req_aio),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .dal_out(dal_out), .dal_oe(dal_oe), .dal_in(dal_in),
        .AIO(AIO), .ALE_n(ALE_n), .SCTL_n(SCTL_n), .BUFCTL_n(BUFCTL_n),
        .dbg_state(dbg_state)
`ifdef DCJ11_MASTER_STATS_EN
        ,
        .stat_clr(stat_clr), .stat_rd(stat_rd), .stat_wr(stat_wr), .stat_nonio(stat_nonio)
`endif
    );

    // ---------------- clock / reset ----------------
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int cyc_cnt = 0;
    always @(posedge sys_clk) cyc_cnt <= cyc_cnt + 1;

    int checks = 0;
    int failures = 0;
    int last_rsp_edge = 0;
    int n_rd = 0, n_wr = 0, n_nonio = 0;
    logic [15:0] last_rdata = 16'h0000;

    // ---------------- spec-level helpers ----------------
    function automatic bit is_rd_code(input logic [3:0] a);
        return a inside {4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1100, 4'b1101, 4'b1110};
    endfunction

    function automatic bit is_wr_code(input logic [3:0] a);
        return a inside {4'b0001, 4'b0011, 4'b0101};
    endfunction

    function automatic logic [15:0] gp_value(input logic [15:0] a);
        return (a[8:0] == 9'd0) ? 16'h0003 : {7'd0, a[8:0]};
    endfunction

    function automatic logic [15:0] init_word(input int i);
        return 16'(i * 257) ^ 16'h5000;
    endfunction

    // ---------------- bus-side responder ----------------
    logic [15:0] bus_mem [0:127];
    bit          bus_init = 1'b0;
    bit          r_lat = 1'b0;
    bit          r_wr_done = 1'b0;
    logic [15:0] r_addr;
    logic [3:0]  r_aio;

    always @(negedge sys_clk) begin
        if (!bus_init) begin
            for (int i = 0; i < 128; i++) bus_mem[i] = init_word(i);
            bus_init = 1'b1;
        end
        if (ALE_n) begin
            r_lat = 1'b0;
            r_wr_done = 1'b0;
        end else if (!r_lat) begin
            r_lat = 1'b1;
            r_addr = dal_out;
            r_aio = AIO;
        end
        if (r_lat && !SCTL_n && !r_wr_done && dal_oe) begin
            r_wr_done = 1'b1;
            if (r_aio == 4'b0001) bus_mem[r_addr[7:1]] = dal_out;
            else if (r_aio == 4'b0011) begin
                if (r_addr[0]) bus_mem[r_addr[7:1]][15:8] = dal_out[15:8];
                else           bus_mem[r_addr[7:1]][7:0]  = dal_out[7:0];
            end
        end
        // Valid read data only while BUFCTL_n is low and before SCTL_n falls.
        if (r_lat && !BUFCTL_n && SCTL_n)
            dal_in = (r_aio == 4'b1110) ? gp_value(r_addr) : bus_mem[r_addr[7:1]];
        else
            dal_in = 16'($urandom);
    end

    // ---------------- request-level reference model ----------------
    logic [15:0] ref_mem [0:127];

    function automatic logic [15:0] ref_read(input logic [3:0] aio, input logic [15:0] addr);
        if (aio == 4'b1110) return gp_value(addr);
        return ref_mem[addr[7:1]];
    endfunction

    task automatic ref_apply(input logic [3:0] aio, input logic [15:0] addr, input logic [15:0] wdata);
        if (aio == 4'b0001) ref_mem[addr[7:1]] = wdata;
        else if (aio == 4'b0011) begin
            if (addr[0]) ref_mem[addr[7:1]][15:8] = wdata[7:0];
            else         ref_mem[addr[7:1]][7:0]  = wdata[7:0];
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    task automatic do_reset();
        RESET_n = 1'b0;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        RESET_n = 1'b1;
        last_rdata = 16'h0000;
        n_rd = 0; n_wr = 0; n_nonio = 0;
    endtask

    task automatic run_txn(input logic [3:0] aio, input logic [15:0] addr, input logic [15:0] wdata,
                           input logic [15:0] exp_rd, input bit b2b, input bit idle_chk);
        bit rd, wr, accepted, done;
        logic r;
        logic [15:0] exp_dal;
        int wait_n, cyc, len, exp_len;
        int sctl_first, sctl_low, buf_low, ale_first, ale_low;
        int rdy_bad, addr_bad, dal_bad, end_bad;
        rd = is_rd_code(aio);
        wr = is_wr_code(aio);
        exp_dal = (aio == 4'b0011) ? {wdata[7:0], wdata[7:0]} : wdata;
        exp_len = (rd || wr) ? T_AS + T_AH + T_ACC + T_STRB + 1 : T_AS + T_AH + 1;
        {sctl_first, sctl_low, buf_low, ale_first, ale_low} = '0;
        {rdy_bad, addr_bad, dal_bad, end_bad, len} = '0;
        ref_apply(aio, addr, wdata);

        @(negedge sys_clk);
        req_aio = aio; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        accepted = 1'b0; wait_n = 0;
        while (!accepted && wait_n < 40) begin
            r = req_ready;
            @(posedge sys_clk);
            if (r) accepted = 1'b1;
            else begin
                @(negedge sys_clk);
                wait_n++;
            end
        end
        #1;
        req_valid = 1'b0;
        check("accept", 32'(accepted), 32'd1);
        if (!accepted) return;
        if (b2b) check("b2b_gap", 32'(cyc_cnt - last_rsp_edge), 32'd2);

        cyc = 1; done = 1'b0;
        while (!done && cyc <= 40) begin
            if (req_ready) rdy_bad++;
            if (!ALE_n) begin ale_low++; if (ale_first == 0) ale_first = cyc; end
            if (!SCTL_n) begin sctl_low++; if (sctl_first == 0) sctl_first = cyc; end
            if (!BUFCTL_n) buf_low++;
            if (cyc == 1 && (dal_out !== addr || dal_oe !== 1'b1 || AIO !== aio)) addr_bad++;
            if (wr && cyc > T_AS + T_AH && cyc < exp_len && (dal_out !== exp_dal || dal_oe !== 1'b1))
                dal_bad++;
            if (rsp_valid) begin
                done = 1'b1;
                len = cyc;
                last_rsp_edge = cyc_cnt;
                if (ALE_n !== 1'b1 || SCTL_n !== 1'b1 || BUFCTL_n !== 1'b1 || dal_oe !== 1'b0 || AIO !== 4'hF)
                    end_bad++;
            end else begin
                @(posedge sys_clk);
                #1;
                cyc++;
            end
        end
        check("rsp_timeout", 32'(done), 32'd1);
        check("len", 32'(len), 32'(exp_len));
        check("ale_first", 32'(ale_first), 32'(T_AS + 1));
        check("ale_low", 32'(ale_low), (rd || wr) ? 32'(T_AH + T_ACC + T_STRB) : 32'(T_AH));
        check("sctl_first", 32'(sctl_first), (rd || wr) ? 32'(T_AS + T_AH + T_ACC + 1) : 32'd0);
        check("sctl_low", 32'(sctl_low), (rd || wr) ? 32'(T_STRB) : 32'd0);
        check("bufctl_low", 32'(buf_low), rd ? 32'(T_ACC + T_STRB) : 32'd0);
        check("ready_busy", 32'(rdy_bad), 32'd0);
        check("addr_phase", 32'(addr_bad), 32'd0);
        check("wdata_hold", 32'(dal_bad), 32'd0);
        check("end_outputs", 32'(end_bad), 32'd0);
        if (rd) last_rdata = exp_rd;
        check("rdata", 32'(rsp_rdata), 32'(last_rdata));
        if (done) begin
            if (rd) n_rd++;
            else if (wr) n_wr++;
            else n_nonio++;
        end
        if (idle_chk) begin
            @(posedge sys_clk);
            #1;
            check("idle_ready", 32'(req_ready), 32'd1);
            check("rsp_pulse", 32'(rsp_valid), 32'd0);
        end
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [3:0]  aio;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        bit          b2b;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  aio;
        logic [15:0] addr, wdata, exp;
        bit cur_b2b, nb, seen;

        for (int i = 0; i < 128; i++) ref_mem[i] = init_word(i);
        req_valid = 1'b0; req_aio = 4'h0; req_addr = 16'h0; req_wdata = 16'h0;
        RESET_n = 1'b1;
`ifdef DCJ11_MASTER_STATS_EN
        stat_clr = 1'b0;
`endif
        #3;
        RESET_n = 1'b0;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_dal_out", 32'(dal_out), 32'd0);
        check("rst_dal_oe", 32'(dal_oe), 32'd0);
        check("rst_aio", 32'(AIO), 32'hF);
        check("rst_strobes", {29'd0, ALE_n, SCTL_n, BUFCTL_n}, 32'h7);
        do_reset();

        // 0o001000 = 16'h0200; 0o001001 = 16'h0201
        vecs[0] = '{4'b0001, 16'h0200, 16'h1234, 16'h0000, 1'b0};
        vecs[1] = '{4'b1001, 16'h0200, 16'h0000, 16'h1234, 1'b0};
        vecs[2] = '{4'b0011, 16'h0201, 16'h00AB, 16'h0000, 1'b1};
        vecs[3] = '{4'b1001, 16'h0200, 16'h0000, 16'hAB34, 1'b1};
        vecs[4] = '{4'b1110, 16'h0000, 16'h0000, 16'h0003, 1'b0};
        vecs[5] = '{4'b1111, 16'h0042, 16'hFFFF, 16'h0000, 1'b0};
        vecs[6] = '{4'b0011, 16'h0200, 16'h77CD, 16'h0000, 1'b1};
        for (int i = 0; i < 7; i++) begin
            nb = (i < 6) ? vecs[i + 1].b2b : 1'b0;
            run_txn(vecs[i].aio, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].b2b, !nb);
        end
        run_txn(4'b1001, 16'h0200, 16'h0000, 16'hABCD, 1'b0, 1'b1);

        // Reset abort in the STRB phase of a write.
        @(negedge sys_clk);
        req_aio = 4'b0001; req_addr = 16'h0010; req_wdata = 16'h5A5A; req_valid = 1'b1;
        @(posedge sys_clk);
        #1;
        req_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(posedge sys_clk);
            #1;
            if (!SCTL_n) seen = 1'b1;
        end
        check("abort_strb_seen", 32'(seen), 32'd1);
        @(negedge sys_clk);
        #2;
        RESET_n = 1'b0;
        #1;
        check("abort_strobes", {29'd0, ALE_n, SCTL_n, BUFCTL_n}, 32'h7);
        check("abort_dal_oe", 32'(dal_oe), 32'd0);
        check("abort_aio", 32'(AIO), 32'hF);
        seen = 1'b0;
        repeat (3) begin
            @(posedge sys_clk);
            #1;
            if (rsp_valid) seen = 1'b1;
        end
        @(negedge sys_clk);
        RESET_n = 1'b1;
        last_rdata = 16'h0000;
        ref_apply(4'b0001, 16'h0010, 16'h5A5A);
        for (int k = 0; k < 3; k++) begin
            @(posedge sys_clk);
            #1;
            if (rsp_valid) seen = 1'b1;
        end
        check("abort_no_rsp", 32'(seen), 32'd0);
        check("abort_ready", 32'(req_ready), 32'd1);
        check("abort_rdata", 32'(rsp_rdata), 32'd0);
        run_txn(4'b1000, 16'h0010, 16'h0000, ref_read(4'b1000, 16'h0010), 1'b0, 1'b1);

        // Random traffic against the reference model.
        cur_b2b = 1'b0;
        for (int i = 0; i < 40; i++) begin
            aio = 4'($urandom_range(0, 15));
            addr = 16'($urandom_range(0, 255));
            wdata = 16'($urandom);
            if ($urandom_range(0, 3) == 0) addr = 16'h0000;
            exp = ref_read(aio, addr);
            nb = ($urandom_range(0, 1) == 1) && (i < 39);
            run_txn(aio, addr, wdata, exp, cur_b2b, !nb);
            cur_b2b = nb;
        end

`ifdef DCJ11_MASTER_STATS_EN
        do_reset();
        run_txn(4'b1001, 16'h0020, 16'h0000, ref_read(4'b1001, 16'h0020), 1'b0, 1'b1);
        run_txn(4'b0001, 16'h0022, 16'hBEEF, 16'h0000, 1'b0, 1'b1);
        run_txn(4'b1110, 16'h0000, 16'h0000, 16'h0003, 1'b0, 1'b1);
        run_txn(4'b1111, 16'h0030, 16'h0000, 16'h0000, 1'b0, 1'b1);
        run_txn(4'b0011, 16'h0023, 16'h0011, 16'h0000, 1'b0, 1'b1);
        run_txn(4'b1000, 16'h0022, 16'h0000, ref_read(4'b1000, 16'h0022), 1'b0, 1'b1);
        check("stat_rd", 32'(stat_rd), 32'd3);
        check("stat_wr", 32'(stat_wr), 32'd2);
        check("stat_nonio", 32'(stat_nonio), 32'd1);
        @(negedge sys_clk);
        stat_clr = 1'b1;
        @(negedge sys_clk);
        stat_clr = 1'b0;
        check("stat_clr", {stat_rd, stat_wr | stat_nonio}, 32'd0);
`endif

        repeat (2) @(posedge sys_clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
